// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared FSM state type, default sizes and the packed-bus field extractor
// used by reg_file_sb and its scoreboard.
package reg_file_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_NUM_RD  = 2;
    localparam int MAX_FIELD_W = 64;
    localparam int MAX_BUS_W   = 4 * MAX_FIELD_W;

    // Field k of width w from a packed bus; callers narrow the result to their own width.
    function automatic logic [MAX_FIELD_W-1:0] unpack_field(
        input logic [MAX_BUS_W-1:0] bus,
        input int                   k,
        input int                   w
    );
        logic [MAX_BUS_W-1:0]   shifted;
        logic [MAX_FIELD_W-1:0] mask;
        shifted = bus >> (k * w);
        mask    = (w >= MAX_FIELD_W) ? '1 : ((64'd1 << w) - 64'd1);
        return shifted[MAX_FIELD_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: decode/writeback side bundle of reg_file_sb; master is the pipeline,
// slave is the register file.
interface reg_file_sb_if #(
    parameter int DATA_W = reg_file_pkg::DEF_DATA_W,
    parameter int ADDR_W = reg_file_pkg::DEF_ADDR_W,
    parameter int NUM_RD = reg_file_pkg::DEF_NUM_RD
);
    logic                     rg_clr_req;
    logic                     rg_ready;
    logic                     rg_wrt_en;
    logic [ADDR_W-1:0]        rg_wrt_addr;
    logic [DATA_W-1:0]        rg_wrt_data;
    logic                     rg_sb_set_en;
    logic [ADDR_W-1:0]        rg_sb_set_addr;
    logic [NUM_RD*ADDR_W-1:0] rg_rd_addr;
    logic [NUM_RD*DATA_W-1:0] rg_rd_data;
    logic [NUM_RD-1:0]        rg_rd_busy;

    modport master (
        output rg_clr_req, rg_wrt_en, rg_wrt_addr, rg_wrt_data,
               rg_sb_set_en, rg_sb_set_addr, rg_rd_addr,
        input  rg_ready, rg_rd_data, rg_rd_busy
    );

    modport slave (
        input  rg_clr_req, rg_wrt_en, rg_wrt_addr, rg_wrt_data,
               rg_sb_set_en, rg_sb_set_addr, rg_rd_addr,
        output rg_ready, rg_rd_data, rg_rd_busy
    );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// reg_file_sb_scoreboard: one pending bit per register, set at issue, cleared at writeback,
// flushed by a clear request, with NUM_RD combinational lookups.
module reg_file_sb_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic                     clr_en,
    input  logic [ADDR_W-1:0]        clr_addr,
    input  logic [NUM_RD*ADDR_W-1:0] lookup_addr,
    output logic [NUM_RD-1:0]        lookup_busy
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0]     pending;
    logic [MAX_BUS_W-1:0] lookup_bus;

    assign lookup_bus = MAX_BUS_W'(lookup_addr);

    // Set is applied after clear so a same-cycle reissue leaves the destination pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else begin
            if (clr_en) pending[clr_addr] <= 1'b0;
            if (set_en) pending[set_addr] <= 1'b1;
        end
    end

    always_comb begin
        lookup_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            lookup_busy[k] = pending[ADDR_W'(unpack_field(lookup_bus, k, ADDR_W))];
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with optional hardwired x0, pending-write scoreboard and a
// self-timed clear sweep. Define REGFILE_BYPASS_EN to forward same-cycle writeback to reads.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input logic          clk,
    input logic          reset,
    reg_file_sb_if.slave rg
);
    localparam int                DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    rf_state_e         state;
    logic [ADDR_W-1:0] clr_ptr;
    logic              ready_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic                     idle;
    logic                     accept_clr;
    logic                     wrt_zero;
    logic                     set_zero;
    logic                     wrt_fire;
    logic                     set_fire;
    logic [MAX_BUS_W-1:0]     rd_addr_bus;
    logic [ADDR_W-1:0]        ra;
    logic [NUM_RD-1:0]        sb_busy;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_RD*DATA_W-1:0] rd_data;

    assign idle        = (state == IDLE);
    assign accept_clr  = idle && rg.rg_clr_req;
    assign wrt_zero    = (ZERO_REG != 0) && (rg.rg_wrt_addr == '0);
    assign set_zero    = (ZERO_REG != 0) && (rg.rg_sb_set_addr == '0);
    assign wrt_fire    = idle && !rg.rg_clr_req && rg.rg_wrt_en && !wrt_zero;
    assign set_fire    = idle && !rg.rg_clr_req && rg.rg_sb_set_en && !set_zero;
    assign rd_addr_bus = MAX_BUS_W'(rg.rg_rd_addr);

    // Sweep walks every entry once; the pointer wraps to 0 on its own after the last entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rg.rg_clr_req) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                        ready_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    clr_ptr <= clr_ptr + ADDR_W'(1);
                    if (clr_ptr == LAST) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_ptr <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage is deliberately unreset; the sweep is what gives it a known value.
    always_ff @(posedge clk) begin
        if (!idle) begin
            mem[clr_ptr] <= '0;
        end else if (wrt_fire) begin
            mem[rg.rg_wrt_addr] <= rg.rg_wrt_data;
        end
    end

    reg_file_sb_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .flush       (accept_clr),
        .set_en      (set_fire),
        .set_addr    (rg.rg_sb_set_addr),
        .clr_en      (wrt_fire),
        .clr_addr    (rg.rg_wrt_addr),
        .lookup_addr (rg.rg_rd_addr),
        .lookup_busy (sb_busy)
    );

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = ADDR_W'(unpack_field(rd_addr_bus, k, ADDR_W));
            if (!idle || ((ZERO_REG != 0) && (ra == '0))) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
                rd_busy[k]                  = 1'b0;
            end
`ifdef REGFILE_BYPASS_EN
            else if (rg.rg_wrt_en && (ra == rg.rg_wrt_addr)) begin
                rd_data[k*DATA_W +: DATA_W] = rg.rg_wrt_data;
                rd_busy[k]                  = 1'b0;
            end
`endif
            else begin
                rd_data[k*DATA_W +: DATA_W] = mem[ra];
                rd_busy[k]                  = sb_busy[k];
            end
        end
    end

    assign rg.rg_rd_data = rd_data;
    assign rg.rg_rd_busy = rd_busy;
    assign rg.rg_ready   = ready_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed bench for reg_file_sb; read expectations are queued when the
// address is driven and checked against the combinational outputs in the same cycle.
module tb_reg_file_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;

    typedef struct {
        string             tag;
        int                port;
        bit                is_busy;
        logic [DATA_W-1:0] exp_val;
    } expect_t;

    logic    clk = 1'b0;
    logic    reset;
    int      assert_count = 0;
    int      fail_count   = 0;
    expect_t exp_q[$];

    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_sb  [DEPTH];
    bit                m_idle;
    int                m_ptr;

    reg_file_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

    reg_file_sb #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rg    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_value(string tag, logic [DATA_W-1:0] observed, logic [DATA_W-1:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference behaviour at a rising edge, using the inputs the bench is holding.
    task automatic model_edge();
        if (!reset) begin
            m_idle = 1'b0;
            m_ptr  = 0;
            foreach (m_sb[i]) m_sb[i] = 1'b0;
        end else if (!m_idle) begin
            m_mem[m_ptr] = '0;
            m_ptr++;
            if (m_ptr == DEPTH) begin
                m_idle = 1'b1;
                m_ptr  = 0;
            end
        end else if (bus.rg_clr_req) begin
            m_idle = 1'b0;
            m_ptr  = 0;
            foreach (m_sb[i]) m_sb[i] = 1'b0;
        end else begin
            if (bus.rg_wrt_en && bus.rg_wrt_addr != '0) begin
                m_mem[bus.rg_wrt_addr] = bus.rg_wrt_data;
                m_sb[bus.rg_wrt_addr]  = 1'b0;
            end
            if (bus.rg_sb_set_en && bus.rg_sb_set_addr != '0) m_sb[bus.rg_sb_set_addr] = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic apply_stimulus(bit wrt_en, logic [ADDR_W-1:0] wrt_addr, logic [DATA_W-1:0] wrt_data,
                                  bit set_en, logic [ADDR_W-1:0] set_addr, bit clr_req);
        bus.rg_wrt_en      = wrt_en;
        bus.rg_wrt_addr    = wrt_addr;
        bus.rg_wrt_data    = wrt_data;
        bus.rg_sb_set_en   = set_en;
        bus.rg_sb_set_addr = set_addr;
        bus.rg_clr_req     = clr_req;
    endtask

    task automatic queue_read(int port, logic [ADDR_W-1:0] addr, string tag);
        logic [DATA_W-1:0] exp_data;
        bit                exp_busy;
        bus.rg_rd_addr[port*ADDR_W +: ADDR_W] = addr;
        if (!m_idle || addr == '0) begin
            exp_data = '0;
            exp_busy = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (bus.rg_wrt_en && bus.rg_wrt_addr == addr) begin
            exp_data = bus.rg_wrt_data;
            exp_busy = 1'b0;
        end
`endif
        else begin
            exp_data = m_mem[addr];
            exp_busy = m_sb[addr];
        end
        exp_q.push_back('{tag: $sformatf("%s.data", tag), port: port, is_busy: 1'b0, exp_val: exp_data});
        exp_q.push_back('{tag: $sformatf("%s.busy", tag), port: port, is_busy: 1'b1, exp_val: DATA_W'(exp_busy)});
    endtask

    task automatic queue_const(int port, logic [DATA_W-1:0] data, bit busy, string tag);
        exp_q.push_back('{tag: $sformatf("%s.data", tag), port: port, is_busy: 1'b0, exp_val: data});
        exp_q.push_back('{tag: $sformatf("%s.busy", tag), port: port, is_busy: 1'b1, exp_val: DATA_W'(busy)});
    endtask

    task automatic check_output();
        expect_t           e;
        logic [DATA_W-1:0] obs;
        #1;
        check_value("ready", DATA_W'(bus.rg_ready), DATA_W'(m_idle));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.is_busy) obs = DATA_W'(bus.rg_rd_busy[e.port]);
            else           obs = bus.rg_rd_data[e.port*DATA_W +: DATA_W];
            check_value(e.tag, obs, e.exp_val);
        end
    endtask

    // Counts edges until ready; with junk set, hammers ignored inputs and checks reads are 0.
    task automatic wait_ready(string tag, int exp_cycles, bit junk);
        int n = 0;
        while (bus.rg_ready !== 1'b1 && n < 64) begin
            if (junk) begin
                apply_stimulus(1'b1, ADDR_W'($urandom), $urandom, 1'b1, ADDR_W'($urandom), 1'b1);
                queue_read(0, ADDR_W'($urandom), "sweep_read");
                queue_const(1, '0, 1'b0, "sweep_read_zero");
                check_output();
            end
            step();
            n++;
        end
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
        check_value(tag, DATA_W'(n), DATA_W'(exp_cycles));
    endtask

    task automatic check_all_zero(string tag);
        for (int i = 0; i < DEPTH; i += 2) begin
            queue_read(0, ADDR_W'(i), tag);
            queue_read(1, ADDR_W'(i + 1), tag);
            queue_const(0, '0, 1'b0, {tag, "_const0"});
            queue_const(1, '0, 1'b0, {tag, "_const1"});
            check_output();
            step();
        end
    endtask

    initial begin
        reset          = 1'b0;
        bus.rg_rd_addr = '0;
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
        foreach (m_mem[i]) m_mem[i] = '0;
        foreach (m_sb[i])  m_sb[i]  = 1'b0;
        m_idle = 1'b0;
        m_ptr  = 0;

        repeat (3) step();
        queue_read(0, 5'd5, "in_reset");
        queue_const(0, '0, 1'b0, "in_reset_const");
        check_output();
        reset = 1'b1;
        wait_ready("sweep_len_after_reset", DEPTH, 1'b0);
        check_all_zero("post_reset_zero");

        apply_stimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0);
        step();
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
        queue_read(0, 5'd5, "x5");
        queue_read(1, 5'd0, "x0");
        queue_const(0, 32'hDEADBEEF, 1'b0, "x5_const");
        queue_const(1, '0, 1'b0, "x0_const");
        check_output();

        apply_stimulus(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 1'b0);
        step();
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
        queue_read(0, 5'd0, "x0_after_write");
        queue_const(0, '0, 1'b0, "x0_after_write_const");
        check_output();

        apply_stimulus(1'b0, '0, '0, 1'b1, 5'd7, 1'b0);
        step();
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
        queue_read(0, 5'd7, "x7_set");
        queue_const(0, '0, 1'b1, "x7_set_const");
        check_output();

        apply_stimulus(1'b1, 5'd7, 32'hA5, 1'b0, '0, 1'b0);
        step();
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
        queue_read(1, 5'd7, "x7_written");
        queue_const(1, 32'hA5, 1'b0, "x7_written_const");
        check_output();

        apply_stimulus(1'b1, 5'd7, 32'h5A, 1'b1, 5'd7, 1'b0);
        step();
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
        queue_read(0, 5'd7, "x7_set_and_write");
        queue_const(0, 32'h5A, 1'b1, "x7_set_and_write_const");
        check_output();

        apply_stimulus(1'b0, '0, '0, 1'b1, 5'd9, 1'b0);
        step();
        apply_stimulus(1'b1, 5'd9, 32'h55AA, 1'b0, '0, 1'b0);
        queue_read(0, 5'd9, "x9_same_cycle");
`ifdef REGFILE_BYPASS_EN
        queue_const(0, 32'h55AA, 1'b0, "x9_bypass_const");
`else
        queue_const(0, '0, 1'b1, "x9_no_bypass_const");
`endif
        check_output();
        step();
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
        queue_read(0, 5'd9, "x9_next_cycle");
        queue_const(0, 32'h55AA, 1'b0, "x9_next_cycle_const");
        check_output();

        for (int i = 1; i < DEPTH; i++) begin
            apply_stimulus(1'b1, ADDR_W'(i), $urandom, 1'b1, ADDR_W'(i), 1'b0);
            step();
        end
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
        queue_read(0, 5'd3, "bulk_x3");
        queue_read(1, 5'd31, "bulk_x31");
        queue_const(1, m_mem[31], 1'b1, "bulk_x31_pending");
        check_output();

        apply_stimulus(1'b1, 5'd4, 32'hFFFF, 1'b1, 5'd4, 1'b1);
        step();
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
        wait_ready("sweep_len_after_clr", DEPTH, 1'b1);
        check_all_zero("post_clr_zero");

        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
        step();
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
        repeat (10) step();
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        wait_ready("sweep_len_after_midsweep_reset", DEPTH, 1'b1);
        queue_read(0, 5'd5, "after_restart_x5");
        queue_const(0, '0, 1'b0, "after_restart_x5_const");
        check_output();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised successor register file for the RISC-V core: configurable data width, depth and read-port count, hardwired zero register, and an integrated pending-write scoreboard. Also provides a self-timed clear sweep after reset or on request. Sits between decode (read addresses, destination issue) and writeback (write port). Hazard logic consumes per-port busy flags instead of tracking destinations itself.

## Interface
Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: number of read ports (1..4).
- ZERO_REG, 1: 1 = entry 0 reads 0, never written, never busy.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low (0 = in reset).
- rg_clr_req  in  1  start a clear sweep (honoured only in IDLE).
- rg_ready  out  1  1 = IDLE; reads, writes and scoreboard operations valid.
- rg_wrt_en  in  1  writeback enable; also clears the destination's pending bit.
- rg_wrt_addr  in  ADDR_W  writeback address.
- rg_wrt_data  in  DATA_W  writeback data.
- rg_sb_set_en  in  1  mark a destination pending (instruction issued).
- rg_sb_set_addr  in  ADDR_W  destination to mark.
- rg_rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W].
- rg_rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
- rg_rd_busy  out  NUM_RD  pending flag for each port's address, combinational.

## Operation
- FSM states: IDLE, CLEAR.
- Reset asserted: state = CLEAR, clear pointer = 0, scoreboard all 0, rg_ready = 0. Storage array is not reset; the sweep clears it.
- CLEAR: write 0 to entry[ptr] each cycle and increment ptr. After the write to entry DEPTH-1, go to IDLE with ptr wrapped to 0.
- While CLEAR: rg_wrt_en, rg_sb_set_en and rg_clr_req are ignored. rg_rd_data is forced to 0 and rg_rd_busy to 0.
- IDLE with rg_clr_req = 1: next state CLEAR, ptr = 0, scoreboard cleared on the same edge. Write and set inputs in that cycle are dropped.
- Write: in IDLE, rg_wrt_en = 1 stores data at rg_wrt_addr and clears sb[rg_wrt_addr].
- Set: in IDLE, rg_sb_set_en = 1 sets sb[rg_sb_set_addr].
- Set and clear to the same address in one cycle: set wins, so the bit ends at 1 (back-to-back reissue).
- ZERO_REG = 1: writes and sets to address 0 are dropped; reads of address 0 return 0 with busy 0.
- Reset asserted mid-sweep or mid-operation: restart from CLEAR with ptr 0.

## Timing
- Read data and busy flags: combinational from the address and current state, 0-cycle latency.
- Write: visible to reads the cycle after the edge (without bypass).
- Scoreboard set/clear: visible the cycle after the edge.
- Sweep length: DEPTH cycles from reset deassertion or from the clr_req acceptance edge; rg_ready rises in cycle DEPTH.
- Throughput: one write and one set per cycle; all NUM_RD reads every cycle.

## Configuration
- REGFILE_BYPASS_EN defined: in IDLE, a read port whose address equals rg_wrt_addr while rg_wrt_en = 1 returns rg_wrt_data, and its busy flag is 0 in the same cycle. ZERO_REG still overrides address 0.
- REGFILE_BYPASS_EN undefined: the read returns the stored (old) value and busy reflects the registered scoreboard. Decode must stall one extra cycle.

## Structure
- Shared package reg_file_pkg holds:
  - state enum (IDLE, CLEAR);
  - default DATA_W / ADDR_W / NUM_RD constants;
  - a function unpacking port k of a packed bus.
- Sub-module reg_file_sb_scoreboard: DEPTH-bit pending vector with set/clear/flush inputs and NUM_RD combinational lookups.
- Storage array, read muxes, bypass and FSM stay in the top module.

## Test plan
- Reset low 3 cycles, then high → rg_ready = 0 for 32 cycles, 1 in cycle 32; every address reads 0x00000000.
- Write 0xDEADBEEF to x5; next cycle read x5 on port 0 and x0 on port 1 → 0xDEADBEEF and 0. Write 0x1234 to x0 → x0 still reads 0.
- Set x7, then read x7 → busy 1. Write x7 = 0xA5 → busy 0 next cycle. Set and write x7 in the same cycle → busy stays 1.
- Bypass: same-cycle write x9 = 0x55AA and read x9 → 0x55AA with busy 0 when REGFILE_BYPASS_EN is defined; old value with busy 1 when it is undefined.
- Pulse rg_clr_req after writing x1..x31 with pending bits set → rg_ready low 32 cycles, writes during the sweep ignored, then all reads 0 with busy 0.
- Assert reset at sweep cycle 10 → sweep restarts; rg_ready rises 32 cycles after reset deassertion.
